// File: rtl/rgb_pwm_fader.sv
// rgb_pwm_fader: multi-channel PWM generator with static or breathe modes, config applied at period boundaries.
module rgb_pwm_fader #(
    parameter int CHANNELS = 3,
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 16,
    parameter int FADE_DIV = 1
) (
    input  logic                                         sys_clk,
    input  logic                                         rst,
    input  logic                                         cfg_valid,
    output logic                                         cfg_ready,
    input  logic [(CHANNELS > 1 ? $clog2(CHANNELS) : 1)-1:0] cfg_chan,
    input  logic [WIDTH-1:0]                             cfg_duty,
    input  logic                                         cfg_mode,
    output logic [CHANNELS-1:0]                          pwm,
    output logic                                         period_start
);
    localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam int FW = FADE_DIV > 1 ? $clog2(FADE_DIV) : 1;
    localparam logic [PW-1:0]    PRE_MAX  = PW'(PRESCALE - 1);
    localparam logic [FW-1:0]    FADE_MAX = FW'(FADE_DIV - 1);
    localparam logic [WIDTH-1:0] CNT_MAX  = '1;

    logic [PW-1:0]       pre_q, pre_d;
    logic [WIDTH-1:0]    cnt_q, cnt_d;
    logic [FW-1:0]       fade_q, fade_d;
    logic [WIDTH-1:0]    sh_duty_q [CHANNELS];
    logic [CHANNELS-1:0] sh_mode_q;
    logic [WIDTH-1:0]    level_q [CHANNELS];
    logic [WIDTH-1:0]    level_d [CHANNELS];
    logic [CHANNELS-1:0] dir_q, dir_d;
    logic [CHANNELS-1:0] pwm_q, pwm_d;
    logic                ps_q, rdy_q;
    logic                tick, boundary, step, wr;

    always_comb begin
        tick     = pre_q == PRE_MAX;
        boundary = tick && cnt_q == CNT_MAX;
        step     = boundary && fade_q == FADE_MAX;
        wr       = cfg_valid && rdy_q && ({1'b0, cfg_chan} < (CW + 1)'(CHANNELS));
        pre_d    = tick ? '0 : pre_q + 1'b1;
        cnt_d    = tick ? cnt_q + 1'b1 : cnt_q;
        fade_d   = boundary ? (step ? '0 : fade_q + 1'b1) : fade_q;
        for (int i = 0; i < CHANNELS; i++) begin
            pwm_d[i]   = level_q[i] > cnt_q;
            level_d[i] = level_q[i];
            dir_d[i]   = dir_q[i];
            // dir 0 = ramping up, 1 = ramping down; shadows are read pre-write so a coincident write waits a period
            if (boundary && !sh_mode_q[i]) begin
                level_d[i] = sh_duty_q[i];
                dir_d[i]   = 1'b0;
            end else if (step && !dir_q[i]) begin
                level_d[i] = level_q[i] < sh_duty_q[i] ? level_q[i] + 1'b1 :
                             (sh_duty_q[i] < level_q[i] ? sh_duty_q[i] : level_q[i]);
                dir_d[i]   = level_q[i] >= sh_duty_q[i];
            end else if (step) begin
                level_d[i] = level_q[i] != '0 ? level_q[i] - 1'b1 : level_q[i];
                dir_d[i]   = level_q[i] != '0;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            pre_q     <= '0;
            cnt_q     <= '0;
            fade_q    <= '0;
            sh_mode_q <= '0;
            dir_q     <= '0;
            pwm_q     <= '0;
            ps_q      <= 1'b0;
            rdy_q     <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                sh_duty_q[i] <= '0;
                level_q[i]   <= '0;
            end
        end else begin
            pre_q  <= pre_d;
            cnt_q  <= cnt_d;
            fade_q <= fade_d;
            dir_q  <= dir_d;
            pwm_q  <= pwm_d;
            ps_q   <= boundary;
            rdy_q  <= 1'b1;
            for (int i = 0; i < CHANNELS; i++) level_q[i] <= level_d[i];
            if (wr) begin
                sh_duty_q[cfg_chan] <= cfg_duty;
                sh_mode_q[cfg_chan] <= cfg_mode;
            end
        end
    end

    assign pwm          = pwm_q;
    assign period_start = ps_q;
    assign cfg_ready    = rdy_q;
endmodule

// File: tb/tb_rgb_pwm_fader.sv
// tb_rgb_pwm_fader: directed and random stimulus against a time-indexed behavioural model of the fader.
module tb_rgb_pwm_fader;
    localparam int NCH = 3;
    localparam int W   = 4;
    localparam int P   = 2;
    localparam int FD  = 1;
    localparam int N   = 1 << W;
    localparam int T   = N * P;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cfg_valid = 1'b0;
    logic         cfg_ready;
    logic [1:0]   cfg_chan = '0;
    logic [W-1:0] cfg_duty = '0;
    logic         cfg_mode = 1'b0;
    logic [NCH-1:0] pwm;
    logic         period_start;

    int total = 0;
    int bad = 0;

    rgb_pwm_fader #(.CHANNELS(NCH), .WIDTH(W), .PRESCALE(P), .FADE_DIV(FD)) dut (
        .sys_clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_chan(cfg_chan), .cfg_duty(cfg_duty), .cfg_mode(cfg_mode),
        .pwm(pwm), .period_start(period_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: state expressed as k = edges since reset; counter position is (k/P)%N.
    int k = 0, nb = 0;
    int mlvl[NCH], shd[NCH];
    bit mdown[NCH], shm[NCH];
    bit mrdy = 0, started = 0;
    logic [NCH-1:0] e_pwm = '0;
    logic e_ps = 0, e_rdy = 0;

    always @(posedge clk) begin
        if (rst) begin
            k = 0; nb = 0; mrdy = 0;
            e_pwm = '0; e_ps = 0; e_rdy = 0;
            for (int i = 0; i < NCH; i++) begin
                mlvl[i] = 0; shd[i] = 0; mdown[i] = 0; shm[i] = 0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) e_pwm[i] = mlvl[i] > (k / P) % N;
            e_ps = ((k + 1) % T) == 0;
            e_rdy = 1;
            if (e_ps) begin
                nb++;
                for (int i = 0; i < NCH; i++) begin
                    if (!shm[i]) begin
                        mlvl[i] = shd[i]; mdown[i] = 0;
                    end else if (nb % FD == 0) begin
                        if (!mdown[i]) begin
                            if (mlvl[i] < shd[i]) mlvl[i]++;
                            else begin mdown[i] = 1; if (shd[i] < mlvl[i]) mlvl[i] = shd[i]; end
                        end else if (mlvl[i] > 0) mlvl[i]--;
                        else mdown[i] = 0;
                    end
                end
            end
            if (cfg_valid && mrdy && cfg_chan < NCH) begin
                shd[cfg_chan] = cfg_duty;
                shm[cfg_chan] = cfg_mode;
            end
            mrdy = 1;
            k++;
        end
        started = 1;
    end

    always @(negedge clk) begin
        if (started) begin
            chk("pwm", pwm, e_pwm);
            chk("period_start", period_start, e_ps);
            chk("cfg_ready", cfg_ready, e_rdy);
        end
    end

    task automatic wr(input int ch, input int d, input bit m);
        cfg_valid = 1; cfg_chan = 2'(ch); cfg_duty = W'(d); cfg_mode = m;
        @(negedge clk);
        cfg_valid = 0;
    endtask

    // Counts high cycles of one channel over the next full period; optionally writes ch0 mid-period and on the last cycle.
    task automatic measure(input int ch, input int exp, input bit mid_en = 0, input int mid_d = 0,
                           input bit mid_m = 0, input bit end_en = 0, input int end_d = 0);
        int n = 0, guard = 0;
        do begin
            @(negedge clk);
            cfg_valid = 0;
            guard++;
        end while (!period_start && guard < 200);
        if (!period_start) begin
            chk("period_start_timeout", 0, 1);
            return;
        end
        for (int j = 0; j < T; j++) begin
            if (j > 0) @(negedge clk);
            n += int'(pwm[ch]);
            if (j == 10 && mid_en) begin
                cfg_valid = 1; cfg_chan = 0; cfg_duty = W'(mid_d); cfg_mode = mid_m;
            end
            if (j == 11) cfg_valid = 0;
            if (j == T - 1 && end_en) begin
                cfg_valid = 1; cfg_chan = 0; cfg_duty = W'(end_d); cfg_mode = 0;
            end
        end
        chk($sformatf("high_ch%0d", ch), n, exp);
    endtask

    int breathe[10] = '{2, 4, 6, 6, 4, 2, 0, 0, 2, 4};

    initial begin
        cfg_valid = 1; cfg_chan = 0; cfg_duty = 9; cfg_mode = 0;
        repeat (3) @(negedge clk);
        chk("rst_pwm", pwm, 0);
        chk("rst_ps", period_start, 0);
        chk("rst_ready", cfg_ready, 0);
        rst = 0;
        @(negedge clk);
        chk("ready_after_rst", cfg_ready, 1);
        cfg_valid = 0;
        measure(0, 0);
        @(negedge clk);
        wr(0, 4, 0);
        wr(1, 0, 0);
        wr(2, 15, 0);
        measure(0, 8);
        measure(0, 8);
        measure(2, 30);
        measure(1, 0);
        measure(0, 8, 1, 12, 0, 1, 2);
        measure(0, 24);
        measure(0, 4, 1, 0, 0);
        measure(0, 0, 1, 3, 1);
        for (int b = 0; b < 10; b++) measure(0, breathe[b]);
        @(negedge clk);
        wr(3, 15, 0);
        measure(2, 30);
        measure(1, 0);
        rst = 1;
        @(negedge clk);
        chk("midrst_pwm", pwm, 0);
        chk("midrst_ready", cfg_ready, 0);
        rst = 0;
        measure(0, 0);
        measure(2, 0);
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst = $urandom_range(0, 599) == 0;
            cfg_valid = $urandom_range(0, 3) == 0;
            cfg_chan = 2'($urandom_range(0, 3));
            cfg_duty = W'($urandom);
            cfg_mode = 1'($urandom);
        end
        @(negedge clk);
        rst = 0; cfg_valid = 0;
        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
